// File: rtl/rc_channel_scheduler.sv
// RC receiver capture: one shared microsecond counter measures each channel's PWM pulse in turn,
// validates and clamps it per channel, strobes complete frames and falls back to defaults on silence.
module rc_channel_scheduler #(
   parameter int NUM_CH      = 6,
   parameter int MIN_US      = 1000,
   parameter int MAX_US      = 2000,
   parameter int GLITCH_US   = 500,
   parameter int TIMEOUT_US  = 2500,
   parameter int FAILSAFE_US = 50000,
   parameter int DEFAULT_US  = 1500,
   parameter int THROTTLE_CH = 0
) (
   input  logic                 us_clk,
   input  logic                 reset,
   input  logic [NUM_CH-1:0]    pwm_in,
   output logic [NUM_CH*11-1:0] ch_values,
   output logic                 frame_strobe,
   output logic                 failsafe,
   output logic                 busy,
   output logic [2:0]           active_ch,
   output logic [7:0]           dropped_cnt
);

   localparam int VW = NUM_CH * 11;
   localparam int BW = $clog2(VW);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_MEASURE  = 2'd1;
   localparam logic [1:0] S_STORE    = 2'd2;
   localparam logic [1:0] S_WAIT_LOW = 2'd3;

   localparam logic [11:0] GLITCH_W     = 12'(GLITCH_US);
   localparam logic [11:0] MIN_W        = 12'(MIN_US);
   localparam logic [11:0] MAX_W        = 12'(MAX_US);
   localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT_US - 1);
   localparam logic [16:0] FS_LAST      = 17'(FAILSAFE_US - 1);
   localparam logic [16:0] FS_SAT       = 17'(FAILSAFE_US);

   function automatic logic [VW-1:0] f_defaults();
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_CH; i++)
         v[i*11 +: 11] = (i == THROTTLE_CH) ? 11'(MIN_US) : 11'(DEFAULT_US);
      return v;
   endfunction

   function automatic logic [3:0] f_count(input logic [NUM_CH-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < NUM_CH; i++)
         n = n + {3'b000, v[i]};
      return n;
   endfunction

   localparam logic [VW-1:0] DEFAULTS = f_defaults();

   logic [NUM_CH-1:0] r_sync1, r_sync2, r_sync_d;
   logic [1:0]        r_state;
   logic [11:0]       r_cnt;
   logic [11:0]       r_raw;
   logic [2:0]        r_active;
   logic [7:0]        r_dropped;
   logic [NUM_CH-1:0] r_fresh;
   logic [16:0]       r_watchdog;
   logic              r_failsafe;
   logic              r_strobe;
   logic [VW-1:0]     r_ch_values;
   logic [VW-1:0]     r_shadow;

   logic [NUM_CH-1:0] w_rise, w_fall, w_active_mask, w_first_oh, w_set_mask;
   logic [2:0]        w_first_idx;
   logic              w_fall_active, w_timeout, w_store, w_complete, w_expire;
   logic [3:0]        w_drop_inc;
   logic [8:0]        w_drop_sum;
   logic [10:0]       w_clamped;
   logic [BW-1:0]     w_base;

   // NOTE: every register below is updated with <= so all flops sample the same pre-edge values.
   always_ff @(posedge us_clk or posedge reset) begin
      if (reset) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_sync_d <= '0;
      end else begin
         r_sync1  <= pwm_in;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
      end
   end

   assign w_rise        = r_sync2 & ~r_sync_d;
   assign w_fall        = ~r_sync2 & r_sync_d;
   assign w_active_mask = NUM_CH'(1) << r_active;
   assign w_first_oh    = w_rise & (~w_rise + NUM_CH'(1));
   assign w_fall_active = |(w_fall & w_active_mask);
   assign w_timeout     = (r_state == S_MEASURE) && !w_fall_active && (r_cnt == TIMEOUT_LAST);

   // NOTE: each always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_first_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (w_rise[i]) w_first_idx = 3'(i);
   end

   // In IDLE only the winning channel is accepted; elsewhere any non-owner rise is lost.
   always_comb begin
      w_drop_inc = '0;
      if (r_state == S_IDLE)
         w_drop_inc = f_count(w_rise & ~w_first_oh);
      else
         w_drop_inc = f_count(w_rise & ~w_active_mask) + {3'b000, w_timeout};
   end

   assign w_drop_sum = {1'b0, r_dropped} + {5'b00000, w_drop_inc};

   always_comb begin
      w_clamped = r_raw[10:0];
      if (r_raw < MIN_W)
         w_clamped = MIN_W[10:0];
      else if (r_raw > MAX_W)
         w_clamped = MAX_W[10:0];
   end

   assign w_store    = (r_state == S_STORE) && (r_raw >= GLITCH_W);
   assign w_set_mask = w_store ? w_active_mask : '0;
   assign w_complete = &r_fresh;
   assign w_expire   = (r_watchdog == FS_LAST);
   assign w_base     = BW'(r_active) * BW'(11);

   always_ff @(posedge us_clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_raw    <= '0;
         r_active <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|w_rise) begin
                  r_active <= w_first_idx;
                  r_cnt    <= '0;
                  r_state  <= S_MEASURE;
               end
            end
            S_MEASURE: begin
               r_cnt <= r_cnt + 12'd1;
               if (w_fall_active) begin
                  r_raw   <= r_cnt;
                  r_state <= S_STORE;
               end else if (r_cnt == TIMEOUT_LAST) begin
                  r_state <= S_WAIT_LOW;
               end
            end
            S_STORE: r_state <= S_IDLE;
            default: begin
               if ((r_sync2 & w_active_mask) == '0)
                  r_state <= S_IDLE;
            end
         endcase
      end
   end

   // The shadow bank always tracks stored values; ch_values follow it only outside failsafe.
   always_ff @(posedge us_clk or posedge reset) begin
      if (reset) begin
         r_ch_values <= DEFAULTS;
         r_shadow    <= DEFAULTS;
         r_fresh     <= '0;
         r_watchdog  <= '0;
         r_failsafe  <= 1'b1;
         r_strobe    <= 1'b0;
         r_dropped   <= '0;
      end else begin
         r_dropped <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
         r_strobe  <= w_complete;
         if (w_store)
            r_shadow[w_base +: 11] <= w_clamped;

         if (w_complete) begin
            r_ch_values <= r_shadow;
            r_fresh     <= w_set_mask;
            r_watchdog  <= '0;
            r_failsafe  <= 1'b0;
         end else if (w_expire) begin
            r_ch_values <= DEFAULTS;
            r_fresh     <= w_set_mask;
            r_watchdog  <= FS_SAT;
            r_failsafe  <= 1'b1;
         end else begin
            r_fresh <= r_fresh | w_set_mask;
            if (r_watchdog != FS_SAT)
               r_watchdog <= r_watchdog + 17'd1;
            if (w_store && !r_failsafe)
               r_ch_values[w_base +: 11] <= w_clamped;
         end
      end
   end

   assign ch_values    = r_ch_values;
   assign frame_strobe = r_strobe;
   assign failsafe     = r_failsafe;
   assign busy         = (r_state != S_IDLE);
   assign active_ch    = r_active;
   assign dropped_cnt  = r_dropped;

endmodule

// File: tb/tb_rc_channel_scheduler.sv
// Bench for rc_channel_scheduler: directed table vectors, multi-cycle corner sequences and
// randomized pulses checked against a pulse-level reference model.
module tb_rc_channel_scheduler;

   localparam int NUM_CH = 6;
   localparam int GAP    = 12;

   logic                 us_clk = 1'b0;
   logic                 reset  = 1'b1;
   logic [NUM_CH-1:0]    pwm_in = '0;
   logic [NUM_CH*11-1:0] ch_values;
   logic                 frame_strobe;
   logic                 failsafe;
   logic                 busy;
   logic [2:0]           active_ch;
   logic [7:0]           dropped_cnt;

   rc_channel_scheduler dut (
      .us_clk       (us_clk),
      .reset        (reset),
      .pwm_in       (pwm_in),
      .ch_values    (ch_values),
      .frame_strobe (frame_strobe),
      .failsafe     (failsafe),
      .busy         (busy),
      .active_ch    (active_ch),
      .dropped_cnt  (dropped_cnt)
   );

   always #5 us_clk = ~us_clk;

   typedef struct {
      int ch;
      int width;
      int exp_val;
      int exp_strobe;
      int exp_fs;
   } vec_t;

   vec_t vecs [19];

   int n_checks = 0;
   int n_errors = 0;

   // Strobe monitor
   int   cyc = 0;
   int   strobe_cnt = 0;
   int   last_strobe_cyc = 0;
   int   strobe_long = 0;
   logic prev_strobe = 1'b0;

   always @(negedge us_clk) begin
      cyc <= cyc + 1;
      if (frame_strobe === 1'b1) begin
         strobe_cnt      <= strobe_cnt + 1;
         last_strobe_cyc <= cyc;
         if (prev_strobe === 1'b1) strobe_long <= strobe_long + 1;
      end
      prev_strobe <= frame_strobe;
   end

   // Pulse-level reference model
   int m_frame [NUM_CH];
   int m_out   [NUM_CH];
   bit m_fresh [NUM_CH];
   int m_dropped;
   bit m_fs;
   int m_strobes = 0;

   function automatic int def_val(input int c);
      return (c == 0) ? 1000 : 1500;
   endfunction

   function automatic int ch_val(input int c);
      return int'(ch_values[c*11 +: 11]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_frame[i] = def_val(i);
         m_out[i]   = def_val(i);
         m_fresh[i] = 1'b0;
      end
      m_dropped = 0;
      m_fs      = 1'b1;
   endtask

   task automatic model_drop();
      if (m_dropped < 255) m_dropped++;
   endtask

   task automatic model_store(input int c, input int raw);
      int v;
      bit all;
      if (raw < 500) return;
      v = (raw < 1000) ? 1000 : (raw > 2000) ? 2000 : raw;
      m_frame[c] = v;
      if (!m_fs) m_out[c] = v;
      m_fresh[c] = 1'b1;
      all = 1'b1;
      for (int i = 0; i < NUM_CH; i++) if (!m_fresh[i]) all = 1'b0;
      if (all) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_out[i]   = m_frame[i];
            m_fresh[i] = 1'b0;
         end
         m_fs = 1'b0;
         m_strobes++;
      end
   endtask

   // The counter starts the cycle after the rise, so a W-cycle pulse reads W-1.
   task automatic model_pulse(input int c, input int w);
      if (w > 2500) model_drop();
      else model_store(c, w - 1);
   endtask

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   task automatic check_near(input string name, input int actual, input int expected, input int tol);
      n_checks++;
      if (actual < expected - tol || actual > expected + tol) begin
         n_errors++;
         $display("FAIL %s: got %0d, want %0d +/-%0d", name, actual, expected, tol);
      end
   endtask

   task automatic check_model(input string tag, input int c);
      check_near({tag, " value"}, ch_val(c), m_out[c], 1);
      check({tag, " dropped"}, int'(dropped_cnt), m_dropped);
      check({tag, " failsafe"}, int'(failsafe), int'(m_fs));
      check({tag, " strobes"}, strobe_cnt, m_strobes);
   endtask

   task automatic drive_pulse(input int c, input int w);
      @(negedge us_clk);
      pwm_in[c] = 1'b1;
      repeat (w) @(negedge us_clk);
      pwm_in[c] = 1'b0;
      repeat (GAP) @(negedge us_clk);
   endtask

   task automatic send_pulse(input int c, input int w);
      drive_pulse(c, w);
      model_pulse(c, w);
   endtask

   task automatic set_vec(input int i, input int c, input int w, input int v, input int s, input int f);
      vecs[i].ch         = c;
      vecs[i].width      = w;
      vecs[i].exp_val    = v;
      vecs[i].exp_strobe = s;
      vecs[i].exp_fs     = f;
   endtask

   task automatic run_vec(input int i);
      int s0;
      s0 = strobe_cnt;
      send_pulse(vecs[i].ch, vecs[i].width);
      check_near($sformatf("vec%0d value", i), ch_val(vecs[i].ch), vecs[i].exp_val, 1);
      check($sformatf("vec%0d strobe", i), strobe_cnt - s0, vecs[i].exp_strobe);
      check($sformatf("vec%0d failsafe", i), int'(failsafe), vecs[i].exp_fs);
      check($sformatf("vec%0d dropped", i), int'(dropped_cnt), 0);
   endtask

   initial begin
      int exp_t2 [NUM_CH];
      int waited;
      int c, w, k;

      // Frame 1 after reset: outputs hold defaults until the frame completes.
      set_vec(0, 0, 1200, 1000, 0, 1);
      set_vec(1, 1, 1300, 1500, 0, 1);
      set_vec(2, 2, 1400, 1500, 0, 1);
      set_vec(3, 3, 1500, 1500, 0, 1);
      set_vec(4, 4, 1600, 1500, 0, 1);
      set_vec(5, 5, 1700, 1700, 1, 0);
      // Glitch rejection and low/high clamping on ch2
      set_vec(6,  0,  600, 1000, 0, 0);
      set_vec(7,  1,  600, 1000, 0, 0);
      set_vec(8,  2,  300, 1400, 0, 0);
      set_vec(9,  2,  900, 1000, 0, 0);
      set_vec(10, 3,  600, 1000, 0, 0);
      set_vec(11, 4,  600, 1000, 0, 0);
      set_vec(12, 5,  600, 1000, 1, 0);
      set_vec(13, 0,  600, 1000, 0, 0);
      set_vec(14, 1,  600, 1000, 0, 0);
      set_vec(15, 2, 2300, 2000, 0, 0);
      set_vec(16, 3,  600, 1000, 0, 0);
      set_vec(17, 4,  600, 1000, 0, 0);
      set_vec(18, 5,  600, 1000, 1, 0);
      exp_t2 = '{1200, 1300, 1400, 1500, 1600, 1700};

      // Reset state
      model_reset();
      reset = 1'b1;
      repeat (5) @(negedge us_clk);
      for (int i = 0; i < NUM_CH; i++) check($sformatf("reset ch%0d", i), ch_val(i), def_val(i));
      check("reset failsafe", int'(failsafe), 1);
      check("reset strobe", int'(frame_strobe), 0);
      check("reset busy", int'(busy), 0);
      check("reset dropped", int'(dropped_cnt), 0);
      reset = 1'b0;
      repeat (3) @(negedge us_clk);

      // Sequential frame, then ch2 glitch/clamp frames
      for (int i = 0; i < 6; i++) run_vec(i);
      for (int i = 0; i < NUM_CH; i++) check_near($sformatf("frame1 ch%0d", i), ch_val(i), exp_t2[i], 1);
      for (int i = 6; i < 19; i++) run_vec(i);

      // Silence: failsafe 50000 cycles after the last frame strobe
      waited = 0;
      while (failsafe !== 1'b1 && waited < 60000) begin
         @(negedge us_clk);
         waited++;
      end
      check("silence failsafe", int'(failsafe), 1);
      check_near("failsafe delay", cyc - last_strobe_cyc, 50000, 1);
      for (int i = 0; i < NUM_CH; i++) check($sformatf("failsafe ch%0d", i), ch_val(i), def_val(i));
      m_fs = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         m_out[i]   = def_val(i);
         m_fresh[i] = 1'b0;
      end

      // ch0 and ch3 rise together: ch0 wins, ch3 dropped
      @(negedge us_clk);
      pwm_in[0] = 1'b1;
      pwm_in[3] = 1'b1;
      repeat (50) @(negedge us_clk);
      check("collide busy", int'(busy), 1);
      check("collide active", int'(active_ch), 0);
      repeat (1050) @(negedge us_clk);
      pwm_in[0] = 1'b0;
      repeat (200) @(negedge us_clk);
      pwm_in[3] = 1'b0;
      repeat (GAP) @(negedge us_clk);
      model_drop();
      model_store(0, 1099);
      check_model("collide ch0", 0);
      check_model("collide ch3", 3);

      // ch1 held high past the timeout
      @(negedge us_clk);
      pwm_in[1] = 1'b1;
      repeat (2700) @(negedge us_clk);
      model_drop();
      check("timeout busy", int'(busy), 1);
      check("timeout active", int'(active_ch), 1);
      check("timeout dropped", int'(dropped_cnt), m_dropped);
      repeat (300) @(negedge us_clk);
      check("wait_low busy", int'(busy), 1);
      pwm_in[1] = 1'b0;
      repeat (GAP) @(negedge us_clk);
      check("wait_low exit", int'(busy), 0);
      check_model("timeout ch1", 1);

      // ch3 was never freshened: no frame until it arrives
      for (int i = 1; i < NUM_CH; i++) begin
         if (i == 3) continue;
         send_pulse(i, 600);
         check_model($sformatf("refill ch%0d", i), i);
      end
      send_pulse(3, 600);
      for (int i = 0; i < NUM_CH; i++) check_model($sformatf("recover ch%0d", i), i);

      // Randomized pulses against the model
      for (int n = 0; n < 6; n++) begin
         c = $urandom_range(NUM_CH - 1, 0);
         k = $urandom_range(9, 0);
         if (k < 6)      w = $urandom_range(2400, 600);
         else if (k < 8) w = $urandom_range(480, 100);
         else if (k < 9) w = $urandom_range(2480, 2100);
         else            w = $urandom_range(2700, 2550);
         send_pulse(c, w);
         check_model($sformatf("rnd%0d ch%0d w%0d", n, c, w), c);
      end

      // Reset asserted mid-measurement
      @(negedge us_clk);
      pwm_in[4] = 1'b1;
      repeat (200) @(negedge us_clk);
      check("mid busy", int'(busy), 1);
      check("mid active", int'(active_ch), 4);
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < NUM_CH; i++) check($sformatf("mid reset ch%0d", i), ch_val(i), def_val(i));
      check("mid reset failsafe", int'(failsafe), 1);
      check("mid reset strobe", int'(frame_strobe), 0);
      check("mid reset busy", int'(busy), 0);
      check("mid reset active", int'(active_ch), 0);
      check("mid reset dropped", int'(dropped_cnt), 0);
      pwm_in = '0;
      repeat (3) @(negedge us_clk);
      reset = 1'b0;
      repeat (10) @(negedge us_clk);
      check("post reset busy", int'(busy), 0);
      check("strobe width", strobe_long, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
